// File: rtl/fifomn_push_arb_pkg.sv
// Shared types and constants for the multi-lane FIFO push arbiter.
// Holds the flush sequencer state encoding and the stall counter width.
// No logic lives here; imported by the arbiter top.
package fifomn_push_arb_pkg;

    typedef enum logic [1:0] {
        ARB_RUN,
        ARB_CLEAR,
        ARB_DONE
    } arb_state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/rr_multi_picker.sv
// Picks up to 'limit' valid requesters, scanning from rr_ptr with wrap-around.
// Latency: purely combinational, zero cycles.
// Backpressure: limit caps the grant count; requesters past the cap get nothing.
module rr_multi_picker #(
    parameter int NUM_REQ = 4,
    parameter int NUM_WR  = 2,
    parameter int PTR_W   = $clog2(NUM_REQ),
    parameter int LIM_W   = $clog2(NUM_WR + 1)
) (
    input  logic [NUM_REQ-1:0]             vld,
    input  logic [PTR_W-1:0]               rr_ptr,
    input  logic [LIM_W-1:0]               limit,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_WR-1:0][NUM_REQ-1:0] lane_sel,
    output logic [PTR_W-1:0]               last_idx
);

    // Walk requesters in priority order; the k-th winner is steered to lane k.
    always_comb begin
        int pos;
        int cnt;
        gnt      = '0;
        lane_sel = '0;
        last_idx = '0;
        pos      = 0;
        cnt      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == pos && vld[j] && cnt < int'(limit)) begin
                    gnt[j] = 1'b1;
                    for (int l = 0; l < NUM_WR; l++) begin
                        if (l == cnt) lane_sel[l][j] = 1'b1;
                    end
                    last_idx = PTR_W'(j);
                    cnt      = cnt + 1;
                end
            end
        end
    end

endmodule

// File: rtl/fifomn_push_arbiter.sv
// Round-robin share of NUM_WR FIFO push lanes among NUM_REQ requesters, plus flush sequencing.
// Latency: vld->rdy/psh combinational (0 cycles); clear/done are registered FSM outputs.
// Backpressure: grants limited by FIFO free space; none while clearing. Option: FIFOMN_PUSH_ARB_STATS_EN.
module fifomn_push_arbiter
    import fifomn_push_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ENTRIES    = 8,
    parameter int ADDR_SIZE  = (ENTRIES == 1) ? 1 : $clog2(ENTRIES),
    parameter int NUM_WR     = 2,
    parameter int NUM_REQ    = 4
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [NUM_REQ-1:0]                  i_req_vld,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]                  o_req_rdy,
    input  logic [ADDR_SIZE:0]                  i_fifo_cnt,
    output logic [NUM_WR-1:0]                   o_psh,
    output logic [NUM_WR-1:0][DATA_WIDTH-1:0]   o_psh_data,
    output logic [ENTRIES-1:0]                  o_fifo_clear,
    input  logic                                i_flush_req,
    output logic                                o_flush_done
`ifdef FIFOMN_PUSH_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]              o_stall_cnt
`endif
);

    localparam int CNT_W = ADDR_SIZE + 1;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int LIM_W = $clog2(NUM_WR + 1);

    arb_state_e                  state;
    logic [PTR_W-1:0]            rr_ptr;
    logic [CNT_W-1:0]            free;
    int                          pop;
    int                          n_gnt;
    logic                        run_en;
    logic [LIM_W-1:0]            limit;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_WR-1:0][NUM_REQ-1:0] lane_sel;
    logic [PTR_W-1:0]            last_idx;

    // Grants only in RUN and never while reset is held.
    assign run_en = (state == ARB_RUN) && !i_reset;

    // Grant budget: smallest of lanes, free slots and valid requesters.
    always_comb begin
        free  = CNT_W'(ENTRIES) - i_fifo_cnt;
        pop   = $countones(i_req_vld);
        n_gnt = NUM_WR;
        if (int'(free) < n_gnt) n_gnt = int'(free);
        if (pop < n_gnt) n_gnt = pop;
        limit = run_en ? LIM_W'(n_gnt) : '0;
    end

    rr_multi_picker #(
        .NUM_REQ (NUM_REQ),
        .NUM_WR  (NUM_WR),
        .PTR_W   (PTR_W),
        .LIM_W   (LIM_W)
    ) u_picker (
        .vld      (i_req_vld),
        .rr_ptr   (rr_ptr),
        .limit    (limit),
        .gnt      (gnt),
        .lane_sel (lane_sel),
        .last_idx (last_idx)
    );

    assign o_req_rdy = gnt;

    // Steer each granted requester's payload onto its lane; idle lanes read zero.
    always_comb begin
        o_psh      = '0;
        o_psh_data = '0;
        for (int l = 0; l < NUM_WR; l++) begin
            o_psh[l] = |lane_sel[l];
            for (int j = 0; j < NUM_REQ; j++) begin
                if (lane_sel[l][j]) o_psh_data[l] = o_psh_data[l] | i_req_data[j];
            end
        end
    end

    // Advance priority past the last winner; hold when nothing was granted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            if (last_idx == PTR_W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                                 rr_ptr <= last_idx + 1'b1;
        end
    end

    // Flush sequencer: RUN -> CLEAR (clear vector high) -> DONE (pulse) -> RUN once request drops.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ARB_RUN;
            o_fifo_clear <= '0;
            o_flush_done <= 1'b0;
        end else begin
            o_fifo_clear <= '0;
            o_flush_done <= 1'b0;
            case (state)
                ARB_RUN: begin
                    if (i_flush_req) begin
                        state        <= ARB_CLEAR;
                        o_fifo_clear <= '1;
                    end
                end
                ARB_CLEAR: begin
                    state        <= ARB_DONE;
                    o_flush_done <= 1'b1;
                end
                ARB_DONE: begin
                    if (!i_flush_req) state <= ARB_RUN;
                end
                default: state <= ARB_RUN;
            endcase
        end
    end

`ifdef FIFOMN_PUSH_ARB_STATS_EN
    logic stall_hit;
    assign stall_hit = (state == ARB_RUN) && (pop != 0) && (n_gnt < pop);

    // Saturating count of RUN cycles where some valid requester was left waiting.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stall_cnt <= '0;
        end else if (state == ARB_RUN && i_flush_req) begin
            o_stall_cnt <= '0;
        end else if (stall_hit && o_stall_cnt != '1) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif

    // A count above depth means the attached FIFO disagrees with ENTRIES.
    a_cnt_legal: assert property (@(posedge i_clk) disable iff (i_reset)
                                  i_fifo_cnt <= CNT_W'(ENTRIES));

endmodule

// File: tb/tb_fifomn_push_arbiter.sv
module tb_fifomn_push_arbiter;
    import fifomn_push_arb_pkg::*;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [3:0]      i_req_vld;
    logic [3:0][3:0] i_req_data;
    logic [3:0]      o_req_rdy;
    logic [3:0]      i_fifo_cnt;
    logic [1:0]      o_psh;
    logic [1:0][3:0] o_psh_data;
    logic [7:0]      o_fifo_clear;
    logic            i_flush_req;
    logic            o_flush_done;
`ifdef FIFOMN_PUSH_ARB_STATS_EN
    logic [15:0]     o_stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 i_clk = ~i_clk;

    fifomn_push_arbiter #(
        .DATA_WIDTH (4),
        .ENTRIES    (8),
        .NUM_WR     (2),
        .NUM_REQ    (4)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_vld    (i_req_vld),
        .i_req_data   (i_req_data),
        .o_req_rdy    (o_req_rdy),
        .i_fifo_cnt   (i_fifo_cnt),
        .o_psh        (o_psh),
        .o_psh_data   (o_psh_data),
        .o_fifo_clear (o_fifo_clear),
        .i_flush_req  (i_flush_req),
        .o_flush_done (o_flush_done)
`ifdef FIFOMN_PUSH_ARB_STATS_EN
        ,
        .o_stall_cnt  (o_stall_cnt)
`endif
    );

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset     = 1'b1;
        i_req_vld   = 4'b1111;
        i_req_data  = {4'hC, 4'h9, 4'h6, 4'h5};
        i_fifo_cnt  = 4'd0;
        i_flush_req = 1'b0;
        #2;
        n_chk++; if (o_req_rdy !== 4'b0000) $display("FAIL reset_rdy: got %b want 0000", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh !== 2'b00) $display("FAIL reset_psh: got %b want 00", o_psh); else n_pass++;
        n_chk++; if (o_fifo_clear !== 8'h00) $display("FAIL reset_clear: got %h want 00", o_fifo_clear); else n_pass++;
        n_chk++; if (o_flush_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_flush_done); else n_pass++;
        next_cycle();
        i_reset   = 1'b0;
        i_req_vld = 4'b0000;
        #2;
        n_chk++; if (dut.state !== ARB_RUN) $display("FAIL reset_state: got %0d want %0d", dut.state, ARB_RUN); else n_pass++;
        n_chk++; if (dut.rr_ptr !== 2'd0) $display("FAIL reset_rrptr: got %0d want 0", dut.rr_ptr); else n_pass++;
        next_cycle();
    endtask

    task automatic test_round_robin();
        i_fifo_cnt = 4'd0;
        i_req_vld  = 4'b1111;
        #2;
        n_chk++; if (o_req_rdy !== 4'b0011) $display("FAIL rr_c1_rdy: got %b want 0011", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh !== 2'b11) $display("FAIL rr_c1_psh: got %b want 11", o_psh); else n_pass++;
        n_chk++; if (o_psh_data !== 8'h65) $display("FAIL rr_c1_data: got %h want 65", o_psh_data); else n_pass++;
        next_cycle();
        #2;
        n_chk++; if (o_req_rdy !== 4'b1100) $display("FAIL rr_c2_rdy: got %b want 1100", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh_data !== 8'hC9) $display("FAIL rr_c2_data: got %h want c9", o_psh_data); else n_pass++;
        next_cycle();
        #2;
        n_chk++; if (o_req_rdy !== 4'b0011) $display("FAIL rr_c3_rdy: got %b want 0011", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh_data !== 8'h65) $display("FAIL rr_c3_data: got %h want 65", o_psh_data); else n_pass++;
        next_cycle();
        n_chk++; if (dut.rr_ptr !== 2'd2) $display("FAIL rr_ptr_after: got %0d want 2", dut.rr_ptr); else n_pass++;
    endtask

    task automatic test_space_limit();
        i_fifo_cnt = 4'd7;
        i_req_vld  = 4'b1111;
        #2;
        n_chk++; if (o_req_rdy !== 4'b0100) $display("FAIL space_rdy: got %b want 0100", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh !== 2'b01) $display("FAIL space_psh: got %b want 01", o_psh); else n_pass++;
        n_chk++; if (o_psh_data !== 8'h09) $display("FAIL space_data: got %h want 09", o_psh_data); else n_pass++;
        next_cycle();
        n_chk++; if (dut.rr_ptr !== 2'd3) $display("FAIL space_rrptr: got %0d want 3", dut.rr_ptr); else n_pass++;
    endtask

    task automatic test_full();
        i_fifo_cnt = 4'd8;
        i_req_vld  = 4'b1111;
        #2;
        n_chk++; if (o_req_rdy !== 4'b0000) $display("FAIL full_rdy: got %b want 0000", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh !== 2'b00) $display("FAIL full_psh: got %b want 00", o_psh); else n_pass++;
        n_chk++; if (o_psh_data !== 8'h00) $display("FAIL full_data: got %h want 00", o_psh_data); else n_pass++;
        next_cycle();
        n_chk++; if (dut.rr_ptr !== 2'd3) $display("FAIL full_rrptr: got %0d want 3", dut.rr_ptr); else n_pass++;
    endtask

    task automatic test_wrap();
        i_fifo_cnt = 4'd0;
        i_req_vld  = 4'b1001;
        #2;
        n_chk++; if (o_req_rdy !== 4'b1001) $display("FAIL wrap_rdy: got %b want 1001", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh_data !== 8'h5C) $display("FAIL wrap_data: got %h want 5c", o_psh_data); else n_pass++;
        next_cycle();
        n_chk++; if (dut.rr_ptr !== 2'd1) $display("FAIL wrap_rrptr: got %0d want 1", dut.rr_ptr); else n_pass++;
    endtask

    task automatic test_sparse();
        i_req_vld = 4'b0000;
        #2;
        n_chk++; if (o_req_rdy !== 4'b0000) $display("FAIL idle_rdy: got %b want 0000", o_req_rdy); else n_pass++;
        next_cycle();
        n_chk++; if (dut.rr_ptr !== 2'd1) $display("FAIL idle_rrptr: got %0d want 1", dut.rr_ptr); else n_pass++;
        i_req_vld = 4'b0100;
        #2;
        n_chk++; if (o_req_rdy !== 4'b0100) $display("FAIL single_rdy: got %b want 0100", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh !== 2'b01) $display("FAIL single_psh: got %b want 01", o_psh); else n_pass++;
        next_cycle();
        n_chk++; if (dut.rr_ptr !== 2'd3) $display("FAIL single_rrptr: got %0d want 3", dut.rr_ptr); else n_pass++;
    endtask

    task automatic test_flush_pulse();
        i_req_vld   = 4'b1111;
        i_flush_req = 1'b1;
        #2;
        n_chk++; if (o_req_rdy !== 4'b1001) $display("FAIL flush_n_rdy: got %b want 1001", o_req_rdy); else n_pass++;
        n_chk++; if (o_fifo_clear !== 8'h00) $display("FAIL flush_n_clear: got %h want 00", o_fifo_clear); else n_pass++;
        next_cycle();
        i_flush_req = 1'b0;
        #2;
        n_chk++; if (o_fifo_clear !== 8'hFF) $display("FAIL flush_n1_clear: got %h want ff", o_fifo_clear); else n_pass++;
        n_chk++; if (o_psh !== 2'b00) $display("FAIL flush_n1_psh: got %b want 00", o_psh); else n_pass++;
        n_chk++; if (o_req_rdy !== 4'b0000) $display("FAIL flush_n1_rdy: got %b want 0000", o_req_rdy); else n_pass++;
`ifdef FIFOMN_PUSH_ARB_STATS_EN
        n_chk++; if (o_stall_cnt !== 16'd0) $display("FAIL flush_stall_clr: got %0d want 0", o_stall_cnt); else n_pass++;
`endif
        next_cycle();
        #2;
        n_chk++; if (o_flush_done !== 1'b1) $display("FAIL flush_n2_done: got %b want 1", o_flush_done); else n_pass++;
        n_chk++; if (o_req_rdy !== 4'b0000) $display("FAIL flush_n2_rdy: got %b want 0000", o_req_rdy); else n_pass++;
        n_chk++; if (o_fifo_clear !== 8'h00) $display("FAIL flush_n2_clear: got %h want 00", o_fifo_clear); else n_pass++;
        next_cycle();
        #2;
        n_chk++; if (o_req_rdy !== 4'b0110) $display("FAIL flush_n3_rdy: got %b want 0110", o_req_rdy); else n_pass++;
        n_chk++; if (o_psh_data !== 8'h96) $display("FAIL flush_n3_data: got %h want 96", o_psh_data); else n_pass++;
        n_chk++; if (o_flush_done !== 1'b0) $display("FAIL flush_n3_done: got %b want 0", o_flush_done); else n_pass++;
        next_cycle();
`ifdef FIFOMN_PUSH_ARB_STATS_EN
        n_chk++; if (o_stall_cnt !== 16'd1) $display("FAIL flush_stall_run: got %0d want 1", o_stall_cnt); else n_pass++;
`endif
    endtask

    task automatic test_flush_hold();
        i_req_vld   = 4'b1111;
        i_flush_req = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        n_chk++; if (o_flush_done !== 1'b1) $display("FAIL hold_done1: got %b want 1", o_flush_done); else n_pass++;
        next_cycle();
        #2;
        n_chk++; if (o_flush_done !== 1'b0) $display("FAIL hold_done2: got %b want 0", o_flush_done); else n_pass++;
        n_chk++; if (o_req_rdy !== 4'b0000) $display("FAIL hold_rdy: got %b want 0000", o_req_rdy); else n_pass++;
        n_chk++; if (dut.state !== ARB_DONE) $display("FAIL hold_state: got %0d want %0d", dut.state, ARB_DONE); else n_pass++;
        i_flush_req = 1'b0;
        next_cycle();
        #2;
        n_chk++; if (o_req_rdy !== 4'b0110) $display("FAIL hold_resume_rdy: got %b want 0110", o_req_rdy); else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_flush();
        i_req_vld   = 4'b0000;
        i_flush_req = 1'b1;
        next_cycle();
        #1;
        n_chk++; if (o_fifo_clear !== 8'hFF) $display("FAIL midrst_clear_pre: got %h want ff", o_fifo_clear); else n_pass++;
        i_reset = 1'b1;
        #1;
        n_chk++; if (o_fifo_clear !== 8'h00) $display("FAIL midrst_clear: got %h want 00", o_fifo_clear); else n_pass++;
        n_chk++; if (dut.state !== ARB_RUN) $display("FAIL midrst_state: got %0d want %0d", dut.state, ARB_RUN); else n_pass++;
        n_chk++; if (dut.rr_ptr !== 2'd0) $display("FAIL midrst_rrptr: got %0d want 0", dut.rr_ptr); else n_pass++;
        i_reset     = 1'b0;
        i_flush_req = 1'b0;
        next_cycle();
        i_req_vld = 4'b1111;
        #2;
        n_chk++; if (o_flush_done !== 1'b0) $display("FAIL midrst_done: got %b want 0", o_flush_done); else n_pass++;
        n_chk++; if (o_req_rdy !== 4'b0011) $display("FAIL midrst_rdy: got %b want 0011", o_req_rdy); else n_pass++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_space_limit();
        test_full();
        test_wrap();
        test_sparse();
        test_flush_pulse();
        test_flush_hold();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
